sram_port_arbiter: RTL

- Shares one single-port data SRAM macro (active-low csb/web, byte write mask, 1-cycle read latency) between two request ports in adapter-style req/gnt/rvalid form.
- Port 0 is the core-side TL-UL SRAM adapter; port 1 is the debug/DMA-side adapter.
- Performs round-robin arbitration, converts 32-bit bit-masks to byte enables, and routes returned read data to the issuing port.

---
 rtl/sram_port_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port SRAM macro with byte write enables.
// Round-robin or fixed-priority grant; read data is routed back to the issuing port.
module sram_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int NB        = DW / 8,
  parameter int FixedPrio = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      req_i,
  output logic [1:0]      gnt_o,
  input  logic [1:0]      we_i,
  input  logic [2*AW-1:0] addr_i,
  input  logic [2*DW-1:0] wdata_i,
  input  logic [2*DW-1:0] wmask_i,
  output logic [1:0]      rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic [1:0]      rerror_o,
  output logic            sram_csb_o,
  output logic            sram_web_o,
  output logic [NB-1:0]   sram_wmask_o,
  output logic [AW-1:0]   sram_addr_o,
  output logic [DW-1:0]   sram_wdata_o,
  input  logic [DW-1:0]   sram_rdata_i
);

  logic          rr_ptr_q, rr_ptr_d;
  logic          rd_pending_q, rd_pending_d;
  logic          rd_owner_q, rd_owner_d;
  logic          sel;
  logic          act;
  logic          we_sel;
  logic [DW-1:0] wm_sel;
  logic [NB-1:0] be;

  always_comb begin
    sel = 1'b0;
    case (req_i)
      2'b10:   sel = 1'b1;
      2'b11:   sel = (FixedPrio != 0) ? 1'b0 : rr_ptr_q;
      default: sel = 1'b0;
    endcase
  end

  // No grant may escape while reset is held.
  assign act    = reset & (|req_i);
  assign gnt_o  = act ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign we_sel = sel ? we_i[1] : we_i[0];
  assign wm_sel = sel ? wmask_i[2*DW-1:DW] : wmask_i[DW-1:0];

  always_comb begin
    be = '0;
    for (int k = 0; k < NB; k++) begin
      be[k] = |wm_sel[8*k +: 8];
    end
  end

  assign sram_csb_o   = ~act;
  assign sram_web_o   = ~(act & we_sel);
  assign sram_wmask_o = (act & we_sel) ? be : '0;
  assign sram_addr_o  = sel ? addr_i[2*AW-1:AW] : addr_i[AW-1:0];
  assign sram_wdata_o = sel ? wdata_i[2*DW-1:DW] : wdata_i[DW-1:0];

  assign rr_ptr_d     = act ? ~sel : rr_ptr_q;
  assign rd_pending_d = act & ~we_sel;
  assign rd_owner_d   = act ? sel : rd_owner_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign rvalid_o = {rd_pending_q & rd_owner_q, rd_pending_q & ~rd_owner_q};
  assign rdata_o  = sram_rdata_i;
  assign rerror_o = 2'b00;

endmodule
